input_debouncer: RTL and testbench

Per-bit synchronizer and debouncer for the board's mechanical switches and keys. Sits directly upstream of the switch-change interrupt slave: it takes raw asynchronous pad levels, synchronizes them into `clk`, and presents glitch-free levels plus a one-cycle change strobe. Bounce never reaches the interrupt logic, so each physical press raises one IRQ.

---
 rtl/input_debouncer.sv | 138 +++++++++++++
 tb/tb_input_debouncer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// input_debouncer
// Per-bit two-flop synchronizer followed by a STABLE/PENDING debounce FSM.
// Each bit must show the same new level on the synchronized input for
// DEBOUNCE_CYCLES consecutive evaluations before clean_out follows it.
// A registered `changed` strobe marks any accepted flip.
// Optional feature macro: INPUT_DEBOUNCER_EDGE_EN adds registered per-bit
// rise/fall strobes; without it rise and fall are constant 0.
module input_debouncer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_BITS        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic             changed,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    // Count value at which a still-mismatching bit is accepted.
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_t;

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;
    logic [WIDTH-1:0] clean_reg;
    logic [WIDTH-1:0] toggle;
    logic             changed_reg;

    // Two-flop synchronizer for the asynchronous pad levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= raw_in;
            sync2_reg <= sync2_next(sync1_reg);
        end
    end

    function automatic logic [WIDTH-1:0] sync2_next(input logic [WIDTH-1:0] s1);
        return s1;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            state_t              state_reg;
            logic [CNT_BITS-1:0] cnt_reg;
            logic                clean_bit_reg;
            logic                mismatch;

            assign mismatch = sync2_reg[gi] ^ clean_bit_reg;
            // cnt is 0 whenever the bit is STABLE, so this also covers the
            // DEBOUNCE_CYCLES == 1 case where the first mismatch flips directly.
            assign toggle[gi]    = mismatch && (cnt_reg == CNT_LAST);
            assign clean_reg[gi] = clean_bit_reg;

            // Debounce FSM: count consecutive mismatches, flip on the last one.
            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg     <= STABLE;
                    cnt_reg       <= '0;
                    clean_bit_reg <= 1'b0;
                end else begin
                    case (state_reg)
                        STABLE: begin
                            if (toggle[gi]) begin
                                clean_bit_reg <= ~clean_bit_reg;
                                cnt_reg       <= '0;
                            end else if (mismatch) begin
                                state_reg <= PENDING;
                                cnt_reg   <= CNT_BITS'(1);
                            end
                        end
                        PENDING: begin
                            if (!mismatch) begin
                                state_reg <= STABLE;
                                cnt_reg   <= '0;
                            end else if (toggle[gi]) begin
                                clean_bit_reg <= ~clean_bit_reg;
                                state_reg     <= STABLE;
                                cnt_reg       <= '0;
                            end else begin
                                cnt_reg <= cnt_reg + CNT_BITS'(1);
                            end
                        end
                        default: begin
                            state_reg <= STABLE;
                            cnt_reg   <= '0;
                        end
                    endcase
                end
            end
        end
    endgenerate

    // One pulse per edge on which any bit flipped, aligned with the new level.
    always_ff @(posedge clk) begin
        if (reset) begin
            changed_reg <= 1'b0;
        end else begin
            changed_reg <= |toggle;
        end
    end

    assign clean_out = clean_reg;
    assign changed   = changed_reg;

`ifdef INPUT_DEBOUNCER_EDGE_EN
    logic [WIDTH-1:0] rise_reg;
    logic [WIDTH-1:0] fall_reg;

    // Direction of each flip, judged from the level before it toggles.
    always_ff @(posedge clk) begin
        if (reset) begin
            rise_reg <= '0;
            fall_reg <= '0;
        end else begin
            rise_reg <= toggle & ~clean_reg;
            fall_reg <= toggle & clean_reg;
        end
    end

    assign rise = rise_reg;
    assign fall = fall_reg;
`else
    assign rise = '0;
    assign fall = '0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer (WIDTH=4, DEBOUNCE_CYCLES=4).
// Reference model: the synchronized input is kept as a sliding window of the
// last DEBOUNCE_CYCLES samples; a bit flips when every sample in the window
// differs from its current clean level.
module tb_input_debouncer;

    localparam int W = 4;
    localparam int D = 4;
`ifdef INPUT_DEBOUNCER_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] raw_in;
    logic [W-1:0] clean_out;
    logic         changed;
    logic [W-1:0] rise;
    logic [W-1:0] fall;

    input_debouncer #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D),
        .CNT_BITS(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .raw_in(raw_in),
        .clean_out(clean_out),
        .changed(changed),
        .rise(rise),
        .fall(fall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state
    logic [W-1:0] m_sync1, m_sync2, m_clean, m_rise, m_fall;
    logic         m_changed;
    logic [W-1:0] hist [D];

    // pulse counters for directed scenarios
    int n_changed;
    int rise_cnt [W];
    int fall_cnt [W];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_changed = 0;
        for (int i = 0; i < W; i++) begin
            rise_cnt[i] = 0;
            fall_cnt[i] = 0;
        end
    endtask

    // Drive one cycle, advance the model, compare every output.
    task automatic tick(input logic [W-1:0] r, input logic rst);
        logic [W-1:0] all_diff;
        logic [W-1:0] old;
        raw_in = r;
        reset  = rst;
        @(posedge clk);
        if (rst) begin
            m_sync1 = '0; m_sync2 = '0; m_clean = '0;
            m_changed = 1'b0; m_rise = '0; m_fall = '0;
            for (int i = 0; i < D; i++) hist[i] = '0;
        end else begin
            for (int i = D - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = m_sync2;
            all_diff = '1;
            for (int i = 0; i < D; i++) all_diff = all_diff & (hist[i] ^ m_clean);
            old       = m_clean;
            m_clean   = m_clean ^ all_diff;
            m_changed = |all_diff;
            m_rise    = EDGE_EN ? (all_diff & ~old) : '0;
            m_fall    = EDGE_EN ? (all_diff & old) : '0;
            // after a flip the window equals the new level, so no refill needed
            m_sync2 = m_sync1;
            m_sync1 = r;
        end
        #1;
        chk("model_clean", 32'(clean_out), 32'(m_clean));
        chk("model_changed", 32'(changed), 32'(m_changed));
        chk("model_rise", 32'(rise), 32'(m_rise));
        chk("model_fall", 32'(fall), 32'(m_fall));
        if (changed) n_changed++;
        for (int i = 0; i < W; i++) begin
            if (rise[i]) rise_cnt[i]++;
            if (fall[i]) fall_cnt[i]++;
        end
    endtask

    initial begin
        logic [W-1:0] r;
        logic         rs;
        raw_in = '0;
        reset  = 1'b1;
        clear_counts();

        // Reset with inputs high, then release
        repeat (3) tick(4'hF, 1'b1);
        chk("rst_clean", 32'(clean_out), 32'h0);
        chk("rst_changed", 32'(changed), 32'h0);
        clear_counts();
        for (int i = 0; i < 5; i++) tick(4'hF, 1'b0);
        chk("rel_clean_before", 32'(clean_out), 32'h0);
        tick(4'hF, 1'b0);
        chk("rel_clean", 32'(clean_out), 32'hF);
        chk("rel_changed", 32'(changed), 32'h1);
        chk("rel_rise", 32'(rise), EDGE_EN ? 32'hF : 32'h0);
        tick(4'hF, 1'b0);
        chk("rel_changed_once", 32'(n_changed), 32'd1);

        // Short glitch on bit 0
        tick(4'h0, 1'b1);
        repeat (3) tick(4'h0, 1'b0);
        clear_counts();
        repeat (3) tick(4'h1, 1'b0);
        repeat (10) tick(4'h0, 1'b0);
        chk("glitch_clean", 32'(clean_out), 32'h0);
        chk("glitch_changed", 32'(n_changed), 32'd0);
        chk("glitch_rise", 32'(rise_cnt[0]), 32'd0);
        chk("glitch_fall", 32'(fall_cnt[0]), 32'd0);

        // Clean press and release on bit 2
        clear_counts();
        for (int i = 0; i < 20; i++) begin
            tick(4'h4, 1'b0);
            if (i == 4) chk("press_before", 32'(clean_out), 32'h0);
            if (i == 5) chk("press_clean", 32'(clean_out), 32'h4);
        end
        chk("press_changed", 32'(n_changed), 32'd1);
        chk("press_rise", 32'(rise_cnt[2]), EDGE_EN ? 32'd1 : 32'd0);
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            tick(4'h0, 1'b0);
            if (i == 4) chk("release_before", 32'(clean_out), 32'h4);
            if (i == 5) chk("release_clean", 32'(clean_out), 32'h0);
        end
        chk("release_changed", 32'(n_changed), 32'd1);
        chk("release_fall", 32'(fall_cnt[2]), EDGE_EN ? 32'd1 : 32'd0);
        chk("release_rise", 32'(rise_cnt[2]), 32'd0);

        // Staggered bits 1 and 3
        tick(4'h0, 1'b1);
        tick(4'h0, 1'b0);
        clear_counts();
        for (int i = 0; i < 15; i++) begin
            tick((i < 2) ? 4'h2 : 4'hA, 1'b0);
            if (i == 5) chk("stagger_first", 32'(clean_out), 32'h2);
            if (i == 7) chk("stagger_second", 32'(clean_out), 32'hA);
        end
        chk("stagger_changed", 32'(n_changed), 32'd2);

        // Same bits together
        tick(4'h0, 1'b1);
        tick(4'h0, 1'b0);
        clear_counts();
        for (int i = 0; i < 15; i++) begin
            tick(4'hA, 1'b0);
            if (i == 5) chk("together_clean", 32'(clean_out), 32'hA);
        end
        chk("together_changed", 32'(n_changed), 32'd1);

        // Reset mid-count on bit 0
        tick(4'h0, 1'b1);
        tick(4'h0, 1'b0);
        repeat (4) tick(4'h1, 1'b0);
        tick(4'h1, 1'b1);
        chk("midrst_clean", 32'(clean_out), 32'h0);
        for (int i = 0; i < 6; i++) begin
            tick(4'h1, 1'b0);
            if (i == 4) chk("midrst_before", 32'(clean_out), 32'h0);
            if (i == 5) chk("midrst_clean_after", 32'(clean_out), 32'h1);
        end

        // Randomized bouncing on all bits, occasional reset
        r = 4'h0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) r[$urandom_range(0, W - 1)] ^= 1'b1;
            rs = ($urandom_range(0, 99) == 0);
            tick(r, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
